seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore serial pattern detector; successor to the fixed 4-bit "1101" detector.
- Adds the following over the fixed detector:
  - generic pattern length
  - runtime-programmable pattern
  - overlap / non-overlap mode
  - input qualifier (x_valid)
  - fill tracking, so no false match before N bits have arrived
- Sits after a serial bit source (switch/debounced input or shift stage); drives an LED/flag and an optional match counter.

Parameters:
- N, 4, pattern length in bits (2..16).
- RESET_PATTERN, 4'b1101 (N bits), pattern loaded at reset.
- RESET_OVERLAP, 1, overlap mode selected at reset (1 = overlapping matches allowed).
- CNT_W, 8, width of the match counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- x_valid  input  1  qualifies x; bit accepted only when 1.
- x  input  1  serial data bit.
- cfg_load  input  1  one-cycle strobe: load cfg_pattern/cfg_overlap.
- cfg_pattern  input  N  new pattern; bit N-1 = oldest (first-received) bit.
- cfg_overlap  input  1  new overlap mode.
- z  output  1  Moore match flag (registered).
- window  output  N  last N accepted bits; bit 0 = newest.
- pattern  output  N  currently active pattern.
- match_count  output  CNT_W  saturating match count (present only with the macro).

Behaviour:
- Reset (reset==0 at posedge):
  - window=0, fill=0, z=0.
  - pattern=RESET_PATTERN, overlap=RESET_OVERLAP.
  - match_count=0.
  - Reset overrides all other inputs.
- State: window (N bits), fill counter 0..N (saturates at N), pattern register, overlap bit.
- Accept (x_valid=1, cfg_load=0):
  - window <= {window[N-2:0], x}.
  - fill <= min(fill+1, N).
- Match condition on the post-shift state: new_window==pattern AND new_fill==N.
- z timing:
  - z is registered from the match condition at the same edge that accepts the final bit.
  - z is visible the cycle after that bit is presented (latency 1 clk).
- x_valid=0:
  - window, fill and z all hold.
  - z stays high until the next accepted bit (Moore: output depends on state only).
- Overlap mode (overlap=1): after a match, window and fill are kept; the next match may reuse trailing bits.
- Non-overlap mode (overlap=0):
  - On a match, fill is cleared to 0 at the same edge (window still shifts).
  - The next match therefore needs N freshly accepted bits.
- cfg_load=1:
  - pattern <= cfg_pattern, overlap <= cfg_overlap.
  - window <= 0, fill <= 0, z <= 0.
  - If x_valid=1 in the same cycle, that bit is discarded (load wins).
- Fill guard: with pattern all-zeros, z must not assert until N zeros have been accepted after reset or load.
- Reset mid-stream: partial match is lost; detection restarts from fill=0.
- window port always reflects the register contents, including the zeros present after reset/load.

Optional Feature:
- Macro: SEQ_DET_MATCH_COUNT_EN.
- Defined:
  - match_count port exists.
  - Increments by 1 on every edge where z is newly set by an accepted bit (one count per match event, not per cycle z is high).
  - Saturates at 2^CNT_W-1.
  - Cleared by reset and by cfg_load.
- Undefined:
  - match_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Overlap, reset pattern 1101, accept stream 1,1,0,1,1,0,1 (x_valid=1 each cycle) -> z=1 in the cycle after bits 4 and 7 only; window=4'b1101 in both cycles.
- Same stream with cfg_load (pattern 1101, cfg_overlap=0) first -> z=1 only after bit 4; bit 7 produces no match (fill=3).
- Stream 1,1,0,1 with x_valid=0 for 3 cycles between bits 2 and 3 -> z=1 after bit 4. Then hold x_valid=0 for 5 cycles -> z stays 1. Next accepted 0 -> z=0.
- Load pattern 0000, then accept 0,0,0 -> z=0 throughout. 4th zero -> z=1. Apply reset=0 for one cycle -> z=0, window=0, pattern=1101.
- Accept 1,1,0; in the next cycle assert cfg_load and x_valid=1 with x=1 -> bit discarded, z=0, fill=0. Following 1,1,0,1 -> match.
- With SEQ_DET_MATCH_COUNT_EN and CNT_W=2, overlap, stream of five overlapping 1101 matches -> match_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised Moore serial pattern detector. It shifts qualified serial bits
// into an N-bit window and raises a registered match flag when the window
// equals the active pattern and at least N bits have been accepted since the
// last reset, configuration load or (in non-overlap mode) the last match.
//
// Handshake: x is consumed on a rising clock edge only when x_valid is 1 and
// cfg_load is 0; there is no back-pressure, so every qualified bit is taken.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   x_valid      in   qualifies x
//   x            in   serial data bit
//   cfg_load     in   one-cycle strobe: load cfg_pattern / cfg_overlap
//   cfg_pattern  in   [N-1:0] new pattern, bit N-1 = first-received bit
//   cfg_overlap  in   new overlap mode (1 = overlapping matches allowed)
//   z            out  registered match flag
//   window       out  [N-1:0] last N accepted bits, bit 0 = newest
//   pattern      out  [N-1:0] currently active pattern
//   match_count  out  [CNT_W-1:0] saturating match count
//                     (only when SEQ_DET_MATCH_COUNT_EN is defined)
//
// Optional feature macro: SEQ_DET_MATCH_COUNT_EN
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N             = 4,
    parameter logic [N-1:0]   RESET_PATTERN = 4'b1101,
    parameter logic           RESET_OVERLAP = 1'b1,
    parameter int             CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic             cfg_overlap,
    output logic             z,
    output logic [N-1:0]     window,
`ifdef SEQ_DET_MATCH_COUNT_EN
    output logic [N-1:0]     pattern,
    output logic [CNT_W-1:0] match_count
`else
    output logic [N-1:0]     pattern
`endif
);

    // Fill counter must represent 0..N inclusive.
    localparam int              FW   = $clog2(N + 1);
    localparam logic [FW-1:0]   FULL = FW'(N);

    logic [N-1:0]  window_q;
    logic [FW-1:0] fill_q;
    logic [N-1:0]  pattern_q;
    logic          overlap_q;
    logic          z_q;

    logic [N-1:0]  window_d;
    logic [FW-1:0] fill_d;
    logic          hit;

    // Post-shift view of the state, used for the match decision so that z is
    // registered at the same edge that accepts the final bit.
    always_comb begin
        window_d = {window_q[N-2:0], x};
        fill_d   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit      = (window_d == pattern_q) && (fill_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            window_q  <= '0;
            fill_q    <= '0;
            pattern_q <= RESET_PATTERN;
            overlap_q <= RESET_OVERLAP;
            z_q       <= 1'b0;
        end else if (cfg_load) begin
            // Load wins over a coincident data bit; that bit is dropped.
            window_q  <= '0;
            fill_q    <= '0;
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
            z_q       <= 1'b0;
        end else if (x_valid) begin
            window_q <= window_d;
            // Non-overlap: a match consumes the window, so the next match
            // needs N fresh bits. The window itself still shifts.
            fill_q   <= (hit && !overlap_q) ? '0 : fill_d;
            z_q      <= hit;
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] count_q;

    // One count per accepted bit that produces a match; hold cycles with z
    // high do not count.
    always_ff @(posedge clk) begin
        if (!reset || cfg_load) begin
            count_q <= '0;
        end else if (x_valid && hit && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign match_count = count_q;
`endif

    assign z       = z_q;
    assign window  = window_q;
    assign pattern = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int           N        = 4;
    localparam int           CNT_W    = 2;
    localparam logic [N-1:0] RST_PAT  = 4'b1101;

    logic             clk;
    logic             reset;
    logic             x_valid;
    logic             x;
    logic             cfg_load;
    logic [N-1:0]     cfg_pattern;
    logic             cfg_overlap;
    logic             z;
    logic [N-1:0]     window;
    logic [N-1:0]     pattern;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    seq_detector_param #(
        .N(N), .RESET_PATTERN(RST_PAT), .RESET_OVERLAP(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .z(z), .window(window),
`ifdef SEQ_DET_MATCH_COUNT_EN
        .pattern(pattern), .match_count(match_count)
`else
        .pattern(pattern)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Window as an integer of the last N accepted bits; "since" counts bits
    // accepted since the last restart point (no saturation needed).
    int m_win, m_since, m_pat, m_cnt;
    bit m_ov, m_z;

    task automatic model_step(input bit rst_n, input bit xv, input bit xb,
                              input bit ld, input int pat, input bit ov);
        bit hit;
        if (!rst_n) begin
            m_win = 0; m_since = 0; m_z = 0; m_pat = int'(RST_PAT); m_ov = 1; m_cnt = 0;
        end else if (ld) begin
            m_win = 0; m_since = 0; m_z = 0; m_pat = pat; m_ov = ov; m_cnt = 0;
        end else if (xv) begin
            m_win   = (m_win * 2 + int'(xb)) % (1 << N);
            m_since = m_since + 1;
            hit     = (m_since >= N) && (m_win == m_pat);
            m_z     = hit;
            if (hit) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                if (!m_ov) m_since = 0;
            end
        end
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive, clock, update model, compare, return at negedge.
    task automatic tick(input bit rst_n, input bit xv, input bit xb,
                        input bit ld, input logic [N-1:0] pat, input bit ov);
        reset = rst_n; x_valid = xv; x = xb; cfg_load = ld;
        cfg_pattern = pat; cfg_overlap = ov;
        @(posedge clk);
        model_step(rst_n, xv, xb, ld, int'(pat), ov);
        #1;
        check("z", 32'(z), 32'(m_z));
        check("window", 32'(window), 32'(m_win));
        check("pattern", 32'(pattern), 32'(m_pat));
`ifdef SEQ_DET_MATCH_COUNT_EN
        check("match_count", 32'(match_count), 32'(m_cnt));
`endif
        @(negedge clk);
    endtask

    task automatic bit_in(input bit b); tick(1, 1, b, 0, '0, 0); endtask
    task automatic idle();              tick(1, 0, $urandom_range(0, 1), 0, '0, 0); endtask
    task automatic rst();               tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), '1, 0); endtask
    task automatic load(input logic [N-1:0] p, input bit ov); tick(1, 0, 0, 1, p, ov); endtask

    logic [6:0] s1;
    logic [6:0] e1;
    logic [6:0] e2;
    int         ce [5];

    initial begin
        reset = 0; x_valid = 0; x = 0; cfg_load = 0; cfg_pattern = '0; cfg_overlap = 0;
        @(negedge clk);
        rst();
        rst();
        check("rst_z", 32'(z), 0);
        check("rst_window", 32'(window), 0);
        check("rst_pattern", 32'(pattern), 32'(RST_PAT));

        // Overlap stream 1101101: matches after bits 4 and 7.
        s1 = 7'b1101101; e1 = 7'b0001001; e2 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            check("tp1_z", 32'(z), 32'(e1[i]));
            if (e1[i]) check("tp1_window", 32'(window), 32'(4'b1101));
        end

        // Same stream, non-overlap: only bit 4 matches.
        rst();
        load(4'b1101, 0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            check("tp2_z", 32'(z), 32'(e2[i]));
        end

        // x_valid gaps do not disturb detection; z holds across idle.
        rst();
        bit_in(1); bit_in(1);
        for (int i = 0; i < 3; i++) begin idle(); check("tp3_gap_z", 32'(z), 0); end
        bit_in(0); bit_in(1);
        check("tp3_match", 32'(z), 1);
        for (int i = 0; i < 5; i++) begin idle(); check("tp3_hold_z", 32'(z), 1); end
        bit_in(0);
        check("tp3_drop", 32'(z), 0);

        // Fill guard with an all-zero pattern.
        load(4'b0000, 1);
        for (int i = 0; i < 3; i++) begin bit_in(0); check("tp4_guard_z", 32'(z), 0); end
        bit_in(0);
        check("tp4_match", 32'(z), 1);
        rst();
        check("tp4_rst_z", 32'(z), 0);
        check("tp4_rst_window", 32'(window), 0);
        check("tp4_rst_pattern", 32'(pattern), 32'(4'b1101));

        // Load beats a coincident data bit.
        bit_in(1); bit_in(1); bit_in(0);
        tick(1, 1, 1, 1, 4'b1101, 1);
        check("tp5_load_z", 32'(z), 0);
        check("tp5_load_window", 32'(window), 0);
        bit_in(1); bit_in(1); bit_in(0);
        check("tp5_partial", 32'(z), 0);
        bit_in(1);
        check("tp5_match", 32'(z), 1);

        // Five overlapping matches; counter saturates at 3 with CNT_W=2.
        rst();
        ce[0] = 1; ce[1] = 2; ce[2] = 3; ce[3] = 3; ce[4] = 3;
        bit_in(1);
        for (int k = 0; k < 5; k++) begin
            bit_in(1); bit_in(0); bit_in(1);
            check("tp6_z", 32'(z), 1);
`ifdef SEQ_DET_MATCH_COUNT_EN
            check("tp6_count", 32'(match_count), 32'(ce[k]));
`endif
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1)       rst();
            else if (r < 3)  tick(1, $urandom_range(0, 1), $urandom_range(0, 1), 1,
                                  N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 1));
            else if (r < 73) bit_in($urandom_range(0, 1));
            else             idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule
